// File: rtl/memory_arbiter_if.sv
// Bundles the two requester channels and the single memory port of memory_arbiter.
// The arbiter connects through the slave modport; the requesters and memory use master.
`timescale 1ns/1ps
interface memory_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  req0_valid;
  logic                  req0_wr;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic                  req0_ready;
  logic                  req1_valid;
  logic                  req1_wr;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic                  req1_ready;

  logic                  rsp0_valid;
  logic [DATA_WIDTH-1:0] rsp0_rdata;
  logic                  rsp0_err;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp1_rdata;
  logic                  rsp1_err;

  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_rsp;

  modport slave (
    input  req0_valid, req0_wr, req0_addr, req0_wdata,
    input  req1_valid, req1_wr, req1_addr, req1_wdata,
    input  mem_rdata, mem_rsp,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_rdata, rsp0_err,
    output rsp1_valid, rsp1_rdata, rsp1_err,
    output mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output req0_valid, req0_wr, req0_addr, req0_wdata,
    output req1_valid, req1_wr, req1_addr, req1_wdata,
    output mem_rdata, mem_rsp,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_rdata, rsp0_err,
    input  rsp1_valid, rsp1_rdata, rsp1_err,
    input  mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/memory_arbiter.sv
// Two-requester round-robin arbiter in front of one memory port, one command in flight.
// Define MEM_ARB_TIMEOUT_EN to abort an ACCESS that sees no mem_rsp within TIMEOUT cycles.
`timescale 1ns/1ps
module memory_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic           clk,
  input  logic           reset,
  memory_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE);

  state_t                state, state_nxt;
  logic                  ptr;        // requester that wins a tie
  logic                  cap_id;
  logic                  cap_wr;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic                  grant0, grant1, grant_any;
  logic                  sel_wr, sel_oor;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  timeout_hit;

  // Grant is gated by reset so ready is 0 while reset is held, even in IDLE.
  always_comb begin
    grant0    = !reset && (state == IDLE) && bus.req0_valid && (!bus.req1_valid || !ptr);
    grant1    = !reset && (state == IDLE) && bus.req1_valid && (!bus.req0_valid ||  ptr);
    grant_any = grant0 || grant1;
    sel_wr    = grant1 ? bus.req1_wr    : bus.req0_wr;
    sel_addr  = grant1 ? bus.req1_addr  : bus.req0_addr;
    sel_wdata = grant1 ? bus.req1_wdata : bus.req0_wdata;
    sel_oor   = ({1'b0, sel_addr} >= MEM_LIMIT);
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // cnt holds the number of ACCESS cycles already spent without mem_rsp.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if ((state == ACCESS) && (state_nxt == ACCESS))
      cnt <= cnt + 1'b1;
    else
      cnt <= '0;
  end

  assign timeout_hit = (state == ACCESS) && !bus.mem_rsp && (cnt == CNT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = sel_oor ? RESP : ACCESS;
      ACCESS:  if (bus.mem_rsp || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // NOTE: the capture registers are reset too; they feed outputs that must read 0 during reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= 1'b0;
      cap_id    <= 1'b0;
      cap_wr    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (grant_any) begin
        cap_id    <= grant1;
        cap_wr    <= sel_wr;
        cap_addr  <= sel_addr;
        cap_wdata <= sel_wdata;
        rdata_q   <= '0;
        err_q     <= sel_oor;
      end
      if (state == ACCESS) begin
        if (bus.mem_rsp) begin
          rdata_q <= cap_wr ? '0 : bus.mem_rdata;
          err_q   <= 1'b0;
        end else if (timeout_hit) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
      if (state == RESP)
        ptr <= ~cap_id;
    end
  end

  // Outputs decode from reset-cleared state, so reset drives them all to 0 asynchronously.
  always_comb begin
    bus.req0_ready = grant0;
    bus.req1_ready = grant1;

    bus.rsp0_valid = (state == RESP) && !cap_id;
    bus.rsp1_valid = (state == RESP) &&  cap_id;
    bus.rsp0_err   = bus.rsp0_valid && err_q;
    bus.rsp1_err   = bus.rsp1_valid && err_q;
    bus.rsp0_rdata = bus.rsp0_valid ? rdata_q : '0;
    bus.rsp1_rdata = bus.rsp1_valid ? rdata_q : '0;

    bus.mem_wr     = (state == ACCESS) && cap_wr;
    bus.mem_addr   = (state == ACCESS) ? cap_addr  : '0;
    bus.mem_wdata  = (state == ACCESS) ? cap_wdata : '0;
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: write, read, contention, range error, timeout, mid-access reset.
`timescale 1ns/1ps
module tb_memory_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  memory_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  memory_arbiter #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .MEM_SIZE(16), .TIMEOUT(15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req0_valid = 1'b0; bus.req0_wr = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
    bus.req1_valid = 1'b0; bus.req1_wr = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
  endtask

  initial begin
    int strobes;
    reset = 1'b1;
    clear_reqs();
    bus.mem_rdata = '0;
    bus.mem_rsp   = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 8'd3;
    #12;
    check("reset_ready0", bus.req0_ready, 0);
    check("reset_mem_wr", bus.mem_wr, 0);
    check("reset_rsp0",   bus.rsp0_valid, 0);
    tick();
    reset = 1'b0;
    clear_reqs();

    // Write from requester 0, memory answers after one ACCESS cycle
    bus.req0_valid = 1'b1; bus.req0_wr = 1'b1; bus.req0_addr = 8'd3; bus.req0_wdata = 32'hDEADBEEF;
    #1;
    check("wr_ready0", bus.req0_ready, 1);
    check("wr_ready1", bus.req1_ready, 0);
    tick();
    clear_reqs();
    #1;
    check("wr_mem_wr",    bus.mem_wr, 1);
    check("wr_mem_addr",  bus.mem_addr, 3);
    check("wr_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    check("wr_no_ready",  bus.req0_ready, 0);
    bus.mem_rsp = 1'b1;
    tick();
    bus.mem_rsp = 1'b0;
    #1;
    check("wr_rsp0_valid", bus.rsp0_valid, 1);
    check("wr_rsp0_err",   bus.rsp0_err, 0);
    check("wr_rsp0_rdata", bus.rsp0_rdata, 0);
    check("wr_rsp1_quiet", bus.rsp1_valid, 0);
    check("wr_mem_wr_off", bus.mem_wr, 0);
    tick();
    check("wr_rsp0_once",  bus.rsp0_valid, 0);

    // Read from requester 1 with a two-cycle memory delay
    bus.req1_valid = 1'b1; bus.req1_wr = 1'b0; bus.req1_addr = 8'd3;
    #1;
    check("rd_ready1", bus.req1_ready, 1);
    tick();
    clear_reqs();
    #1;
    check("rd_mem_wr",   bus.mem_wr, 0);
    check("rd_mem_addr", bus.mem_addr, 3);
    tick();
    check("rd_wait", bus.rsp1_valid, 0);
    bus.mem_rsp = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    tick();
    bus.mem_rsp = 1'b0; bus.mem_rdata = '0;
    #1;
    check("rd_rsp1_valid", bus.rsp1_valid, 1);
    check("rd_rsp1_rdata", bus.rsp1_rdata, 32'hDEADBEEF);
    check("rd_rsp1_err",   bus.rsp1_err, 0);
    tick();

    // mem_rsp in IDLE must not produce a response
    bus.mem_rsp = 1'b1;
    tick();
    tick();
    bus.mem_rsp = 1'b0;
    check("idle_rsp_ignored", bus.rsp0_valid | bus.rsp1_valid, 0);

    // Contention straight after reset: grants alternate 0,1,0,1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_addr = 8'd5;
    bus.req1_valid = 1'b1; bus.req1_addr = 8'd6;
    bus.mem_rsp = 1'b1; bus.mem_rdata = 32'h000000A5;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr%0d_ready0", i), bus.req0_ready, (i % 2) == 0);
      check($sformatf("rr%0d_ready1", i), bus.req1_ready, (i % 2) == 1);
      tick();
      check($sformatf("rr%0d_addr", i), bus.mem_addr, ((i % 2) == 0) ? 5 : 6);
      tick();
      check($sformatf("rr%0d_rsp0", i), bus.rsp0_valid, (i % 2) == 0);
      check($sformatf("rr%0d_rsp1", i), bus.rsp1_valid, (i % 2) == 1);
      check($sformatf("rr%0d_no_ready", i), bus.req0_ready | bus.req1_ready, 0);
      tick();
    end
    clear_reqs();
    bus.mem_rsp = 1'b0; bus.mem_rdata = '0;

    // Out-of-range address goes straight to an error response
    bus.req0_valid = 1'b1; bus.req0_wr = 1'b1; bus.req0_addr = 8'd16; bus.req0_wdata = 32'h11111111;
    #1;
    check("oor_ready0", bus.req0_ready, 1);
    tick();
    clear_reqs();
    #1;
    check("oor_rsp0_valid", bus.rsp0_valid, 1);
    check("oor_rsp0_err",   bus.rsp0_err, 1);
    check("oor_rsp0_rdata", bus.rsp0_rdata, 0);
    check("oor_mem_wr",     bus.mem_wr, 0);
    check("oor_mem_addr",   bus.mem_addr, 0);
    tick();

    // Last valid address, memory never answers
    bus.req1_valid = 1'b1; bus.req1_wr = 1'b1; bus.req1_addr = 8'd15; bus.req1_wdata = 32'h0000CAFE;
    #1;
    check("to_ready1", bus.req1_ready, 1);
    tick();
    clear_reqs();
    #1;
    check("to_mem_addr", bus.mem_addr, 15);
    check("to_mem_wr",   bus.mem_wr, 1);
`ifdef MEM_ARB_TIMEOUT_EN
    strobes = 0;
    for (int j = 1; j < 15; j++) begin
      tick();
      strobes += int'(bus.rsp1_valid);
    end
    check("to_no_early_rsp", strobes, 0);
    check("to_cycle15_mem_wr", bus.mem_wr, 1);
    tick();
    check("to_rsp1_valid", bus.rsp1_valid, 1);
    check("to_rsp1_err",   bus.rsp1_err, 1);
    check("to_rsp1_rdata", bus.rsp1_rdata, 0);
    check("to_mem_wr_off", bus.mem_wr, 0);
    tick();
    bus.req0_valid = 1'b1; bus.req0_addr = 8'd2;
    #1;
    check("to_next_ready0", bus.req0_ready, 1);
    tick();
    check("to_next_addr", bus.mem_addr, 2);
`else
    strobes = 0;
    for (int j = 0; j < 100; j++) begin
      tick();
      strobes += int'(bus.rsp1_valid);
    end
    check("noto_no_rsp",  strobes, 0);
    check("noto_mem_wr",  bus.mem_wr, 1);
    check("noto_mem_addr", bus.mem_addr, 15);
`endif

    // Reset pulse while in ACCESS clears outputs at once, no response follows
    bus.req0_valid = 1'b1; bus.req0_addr = 8'd4;
    #2;
    reset = 1'b1;
    #1;
    check("rst_mem_wr",    bus.mem_wr, 0);
    check("rst_mem_addr",  bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_ready0",    bus.req0_ready, 0);
    check("rst_rsp",       bus.rsp0_valid | bus.rsp1_valid, 0);
    clear_reqs();
    bus.mem_rsp = 1'b1;
    tick();
    reset = 1'b0;
    bus.mem_rsp = 1'b0;
    strobes = 0;
    for (int j = 0; j < 3; j++) begin
      strobes += int'(bus.rsp0_valid | bus.rsp1_valid);
      tick();
    end
    check("rst_no_strobe", strobes, 0);

    // Lone requester 1 wins even though the pointer favours 0 after reset
    bus.req1_valid = 1'b1; bus.req1_wr = 1'b0; bus.req1_addr = 8'd7;
    #1;
    check("post_ready1", bus.req1_ready, 1);
    tick();
    clear_reqs();
    check("post_mem_addr", bus.mem_addr, 7);
    bus.mem_rsp = 1'b1; bus.mem_rdata = 32'h12345678;
    tick();
    bus.mem_rsp = 1'b0; bus.mem_rdata = '0;
    check("post_rsp1_valid", bus.rsp1_valid, 1);
    check("post_rsp1_rdata", bus.rsp1_rdata, 32'h12345678);
    check("post_rsp1_err",   bus.rsp1_err, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
